dm_responder: RTL

//   Memory-side responder for pipeline data-memory accesses.

---
 rtl/dm_responder_pkg.sv | 24 ++
 rtl/dm_responder_if.sv | 26 ++
 rtl/dm_word_array.sv | 26 ++
 rtl/dm_responder.sv | 116 +++++++++++
 4 files changed

// File: rtl/dm_responder_pkg.sv
// Shared types and constants for the data-memory responder: FSM state encoding,
// word width, error response value and the address legality check.
package dm_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DM_WORD_W = 32;
    localparam logic [DM_WORD_W-1:0] DM_ERR_RDATA = '0;

    // Wide enough for LATENCY-1 with LATENCY up to 15.
    localparam int CNT_W = 4;

    // Misaligned byte address or word index beyond the array; upper bits never alias.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        logic [31:0] word_idx;
        word_idx = {2'b00, addr[31:2]};
        return (addr[1:0] != 2'b00) || (word_idx >= 32'(depth));
    endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Request/response channel between the EX/MEM stage (master) and the
// data-memory responder (slave).
interface dm_responder_if;
    import dm_responder_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [31:0]          req_addr;
    logic [DM_WORD_W-1:0] req_wdata;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DM_WORD_W-1:0] rsp_rdata;
    logic                 rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dm_word_array.sv
// Word storage for the responder: synchronous write with enable, combinational
// read, no reset so contents survive a responder reset.
module dm_word_array
    import dm_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        addr,
    input  logic [DM_WORD_W-1:0] wdata,
    output logic [DM_WORD_W-1:0] rdata
);

    logic [DM_WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dm_responder.sv
// Fixed-latency valid/ready data-memory responder: one word read or write per
// transaction, response held on a separate channel until consumed.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic           clk,
    input  logic           rst,
    dm_responder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic                 rsp_valid, rsp_valid_n;
    logic                 rsp_err, rsp_err_n;
    logic [DM_WORD_W-1:0] rsp_rdata, rsp_rdata_n;

    logic                 lat_we;
    logic [31:0]          lat_addr;
    logic [DM_WORD_W-1:0] lat_wdata;

    logic                 accept;
    logic                 finish;
    logic                 lat_err;
    logic                 mem_we;
    logic [DM_WORD_W-1:0] mem_rdata;

    assign accept  = bus.req_valid && (state == IDLE);
    assign finish  = (state == WAIT) && (cnt == '0);
    assign lat_err = addr_err(lat_addr, DEPTH_WORDS);
    // The write commits on the same edge that enters RESP, so a reset during WAIT drops it.
    assign mem_we  = finish && lat_we && !lat_err;

    dm_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (lat_addr[AW+1:2]),
        .wdata (lat_wdata),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        rsp_valid_n = rsp_valid;
        rsp_err_n   = rsp_err;
        rsp_rdata_n = rsp_rdata;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = WAIT;
                    cnt_n   = CNT_W'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    state_n     = RESP;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = lat_err;
                    rsp_rdata_n = (lat_we || lat_err) ? DM_ERR_RDATA : mem_rdata;
                end
            end
            RESP: begin
                // A request presented on this edge waits for IDLE; only the response is consumed.
                if (bus.rsp_ready) begin
                    state_n     = IDLE;
                    rsp_valid_n = 1'b0;
                    rsp_err_n   = 1'b0;
                    rsp_rdata_n = '0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rsp_valid <= rsp_valid_n;
            rsp_err   <= rsp_err_n;
            rsp_rdata <= rsp_rdata_n;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_we    <= bus.req_we;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_err   = rsp_err;
    assign bus.rsp_rdata = rsp_rdata;

endmodule
